eth_halfwidth_tx: RTL
=====================

Name: eth_halfwidth_tx

Overview:
- Inverse of the double-width input path: converts the 128-bit packet stream returned from the processing core back to 64-bit transmit beats for one Ethernet port.
- Sits between the per-port output of the packet memory group and the 64-bit transmitout_* interface. Its output is Avalon-ST style: valid/ready/sop/eop/empty.
- Preserves byte order and packet boundaries. Sustains one 64-bit output beat per cycle.

Parameters:
- IN_W, 128, input data width; must equal 2*OUT_W.
- OUT_W, 64, output data width.
- CH_W, 2, channel tag width; the tag is passed through unchanged.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  IN_W  input word; the first-transmitted half is in [127:64].
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word.
- in_sop  in  1  first word of packet.
- in_eop  in  1  last word of packet.
- in_empty  in  4  empty bytes in the eop word (0..15).
- in_channel  in  CH_W  source channel tag.
- out_data  out  OUT_W  output beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sop  out  1  first beat of packet.
- out_eop  out  1  last beat of packet.
- out_empty  out  3  empty bytes in the eop beat (0..7).
- out_channel  out  CH_W  channel tag of the current beat.
- err  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Transfer rules: input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
- Storage: one 128-bit holding register plus its sop/eop/empty/channel, and a phase FSM.
- FSM states:
  - IDLE: register empty.
  - HI: presenting [127:64].
  - LO: presenting [63:0].
- in_ready = (state==IDLE) | (out_ready & out_valid & last_half), where last_half = (state==LO) | (state==HI & short). This is a combinational dependence on out_ready; no other combinational input-to-output paths.
- short = held eop & held empty >= 8.
- IDLE:
  - On input transfer, load the register and go to HI; out_valid rises the next cycle (latency 1).
- HI:
  - out_data = reg[127:64]; out_sop = held sop.
  - out_eop = short; out_empty = short ? held empty-8 : 0.
  - On output transfer with !short: go to LO.
  - On output transfer with short: if an input transfer occurs the same cycle, load it and stay HI; otherwise go to IDLE.
- LO:
  - out_data = reg[63:0]; out_sop = 0.
  - out_eop = held eop; out_empty = held eop ? held empty[2:0] : 0.
  - On output transfer: load the new word and go to HI if an input transfer occurs the same cycle; otherwise go to IDLE.
- Throughput: back-to-back input words produce a gap-free output stream, one beat per cycle.
- out_channel = held channel on both halves.
- Stall: while out_valid & !out_ready, all out_* signals hold stable.
- out_valid never drops without a transfer.
- in_empty is ignored when in_eop = 0; the word is treated as full.
- A word with in_sop & in_eop (single-word packet) yields a packet of 1 or 2 output beats; the first beat carries sop.
- Reset:
  - Return to IDLE; holding register cleared.
  - out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0, out_channel=0, err=0.
  - in_ready=0 while reset is high; in_ready=1 the first cycle after.
  - Reset mid-packet discards the held word; no partial beat is emitted after reset.

Optional Feature:
- Macro: HALFWIDTH_PROTO_CHECK_EN.
- When defined, the block tracks an in_packet bit updated on input transfers: set on sop, cleared on eop.
- err sets, and stays set until reset, on either violation:
  - an input transfer with in_sop while in_packet;
  - an input transfer without in_sop while !in_packet.
- Data flow is unaffected by err.
- When undefined, err is tied to 0 and no tracking logic is built.

Test Plan:
- Reset, then one word with sop=1, eop=1, empty=0, data {A,B} -> two beats: A (sop=1, eop=0) then B (sop=0, eop=1, empty=0); first out_valid 1 cycle after acceptance.
- eop word with empty=11 -> a single beat with upper half, eop=1, empty=3; the lower half is never emitted.
- Packet of 95 words with out_ready held 1 -> 190 contiguous beats, no bubbles, in_ready high every other cycle; data matches the input sequence.
- Random out_ready (~97% high), 10000 packets of 95 words -> scoreboard of 64-bit beats matches exactly; out_* stable across every stall.
- Reset asserted while in LO mid-packet -> the next cycle out_valid=0, in_ready=0; after release, a new packet outputs correctly with sop on its first beat.
- With HALFWIDTH_PROTO_CHECK_EN: two consecutive sop words with no eop -> err=1 from the cycle after the second accept until reset. Without the macro: err=0 throughout.

Source files
------------

// File: rtl/eth_halfwidth_tx.sv
// 128->64 transmit width converter: one 1-word holding register split into hi/lo beats; latency 1 cycle.
// Output holds stable under out_ready stall; in_ready depends on out_ready. Optional HALFWIDTH_PROTO_CHECK_EN builds the sop/eop checker.
module eth_halfwidth_tx #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 64,
  parameter int CH_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [3:0]        in_empty,
  input  logic [CH_W-1:0]   in_channel,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [2:0]        out_empty,
  output logic [CH_W-1:0]   out_channel,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   hold_data;
  logic              hold_sop;
  logic              hold_eop;
  logic [3:0]        hold_empty;
  logic [CH_W-1:0]   hold_channel;

  logic short_word;
  logic last_half;
  logic in_xfer;

  // A short eop word has no valid bytes in its lower half, so it ends after the hi beat.
  assign short_word = hold_eop & (hold_empty >= 4'd8);
  assign last_half  = (state == LO) | ((state == HI) & short_word);
  assign in_ready   = !reset & ((state == IDLE) | (out_ready & out_valid & last_half));
  assign in_xfer    = in_valid & in_ready;

  assign out_channel = hold_channel;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = hold_data[IN_W-1:OUT_W];
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = 3'd0;
    case (state)
      IDLE: begin
        if (in_xfer) state_nxt = HI;
      end
      HI: begin
        out_valid = 1'b1;
        out_sop   = hold_sop;
        out_eop   = short_word;
        // empty is 8..15 here, so empty-8 is just its low three bits
        out_empty = short_word ? hold_empty[2:0] : 3'd0;
        if (out_ready) begin
          if (!short_word)  state_nxt = LO;
          else if (in_xfer) state_nxt = HI;
          else              state_nxt = IDLE;
        end
      end
      LO: begin
        out_valid = 1'b1;
        out_data  = hold_data[OUT_W-1:0];
        out_eop   = hold_eop;
        out_empty = hold_eop ? hold_empty[2:0] : 3'd0;
        if (out_ready) state_nxt = in_xfer ? HI : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      hold_data    <= '0;
      hold_sop     <= 1'b0;
      hold_eop     <= 1'b0;
      hold_empty   <= 4'd0;
      hold_channel <= '0;
    end else begin
      state <= state_nxt;
      if (in_xfer) begin
        hold_data    <= in_data;
        hold_sop     <= in_sop;
        hold_eop     <= in_eop;
        hold_empty   <= in_eop ? in_empty : 4'd0;
        hold_channel <= in_channel;
      end
    end
  end

`ifdef HALFWIDTH_PROTO_CHECK_EN
  logic in_packet;
  logic err_q;

  // Both violations reduce to in_sop matching the current in_packet state.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_packet <= 1'b0;
      err_q     <= 1'b0;
    end else if (in_xfer) begin
      if (in_sop == in_packet) err_q <= 1'b1;
      if (in_eop)              in_packet <= 1'b0;
      else if (in_sop)         in_packet <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
